main_mem_responder: RTL and testbench
=====================================

// Module: main_mem_responder
// PURPOSE
//  Backing main-memory model that answers line-fill and write-back requests from the
//  multi-cycle CPU's data cache. Sits below the cache as the responder end of the
//  cache<->memory request/response interface. Fixed, programmable access latency
//  stresses the cache miss FSM. One request in flight at a time.
// PARAMETERS
//  ADDR_W     32   byte-address width
//  LINE_W     128  cache-line width in bits (multiple of 8, power of two bytes)
//  DEPTH      256  number of lines stored (power of two)
//  LATENCY    4    cycles from request accept to resp_valid (>=1)
//  INIT_FILE  ""   optional $readmemh image; empty = contents undefined (X)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  req_valid   in   1       cache presents a request
//  req_ready   out  1       responder can accept (high only in IDLE)
//  req_write   in   1       1 = write-back line, 0 = line fill
//  req_addr    in   ADDR_W  byte address; low log2(LINE_W/8) bits ignored
//  req_wdata   in   LINE_W  line data for writes
//  resp_valid  out  1       response available
//  resp_ready  in   1       cache accepts response
//  resp_write  out  1       echoes req_write of the completed request
//  resp_rdata  out  LINE_W  line data (reads); 0 for write acks
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, req_ready=1, resp_valid=0,
//   resp_write=0, resp_rdata=0, counter=0. Memory array NOT cleared.
//  Line index = req_addr[OFS+log2(DEPTH)-1:OFS], OFS=log2(LINE_W/8); upper bits
//   ignored -> addresses alias/wrap modulo DEPTH lines.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: accept when req_valid&req_ready at edge T; latch write flag, index, wdata;
//    counter=LATENCY-1; go WAIT (LATENCY==1: go directly to RESP).
//   WAIT: counter decrements each cycle; at 0 go RESP. req_ready=0.
//   RESP: resp_valid=1 first at cycle T+LATENCY. On entry: write -> mem[idx]<=wdata,
//    resp_rdata=0; read -> resp_rdata<=mem[idx]. resp_* held stable while
//    resp_valid&!resp_ready. On resp_ready: resp_valid=0, back to IDLE next cycle.
//  No accept in the cycle resp handshake completes; min request spacing LATENCY+1.
//  Read after write to same line returns the new data (write commits before ack).
//  Inputs ignored outside IDLE; req_valid may drop without effect while busy.
//  Reset mid-WAIT/RESP: request abandoned, no memory write occurs if reset precedes
//   RESP entry; resp_valid drops immediately (async).
//  X on req_* while req_valid=0 must not propagate to state.
// STRUCTURE
//  Shared include mem_if_defs.vh: LINE_W, state encodings (ST_IDLE/WAIT/RESP),
//   offset-width macro, shared with the cache miss FSM.
//  One sub-module: mem_lat_counter (load, decrement, zero flag), also reused by the
//   cache for timeouts. Array is a plain reg [LINE_W-1:0] mem [0:DEPTH-1].
// TESTING
//  1. Write 0x...DEADBEEF to addr 0x40, resp_ready=1 -> resp_valid at T+4, resp_write=1,
//     rdata=0; then read 0x40 -> rdata==0x...DEADBEEF at T'+4.
//  2. Read with resp_ready=0 for 6 cycles -> resp_valid and rdata stable, req_ready=0,
//     new req_valid ignored; release -> IDLE one cycle later.
//  3. Alias: DEPTH=256, LINE_W=128, write addr 0x1000 then read 0x0000 -> same line data.
//  4. Assert reset during WAIT of a write to 0x80 -> outputs reset at once; later read of
//     0x80 returns prior contents (write never committed).
//  5. LATENCY=1 build: back-to-back read/write pairs with resp_ready tied 1 -> each
//     resp_valid exactly 1 cycle after accept, accepts every 2 cycles.
//  6. Random cache-like traffic vs scoreboard array, 1000 requests -> zero mismatches.

Source files
------------

// File: rtl/main_mem_responder_pkg.sv
// main_mem_responder_pkg: FSM states and line-geometry helper shared by the cache<->memory interface
package main_mem_responder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  function automatic int ofs_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter with zero flag, used for access latency and timeouts
module mem_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= load ? load_val : dec ? count - W'(1) : count;
  assign zero = count == '0;
endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency backing memory answering cache line fills and write-backs
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [LINE_W-1:0] resp_rdata
);
  localparam int OFS = ofs_w(LINE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  // counter holds the WAIT cycles still to go minus one, so zero means "enter RESP now"
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_t st, nxt;
  logic ld, dec, cnt_zero, enter_resp, wr_q, wr_c, unused_addr;
  logic [IDX_W-1:0] idx_q, idx_c;
  logic [LINE_W-1:0] wdata_q, wdata_c;
  logic [LINE_W-1:0] mem [0:DEPTH-1];
  assign unused_addr = ^{req_addr[ADDR_W-1:OFS+IDX_W], req_addr[OFS-1:0]};
  mem_lat_counter #(.W(CNT_W)) u_cnt (
    .clk,
    .reset,
    .load(ld),
    .dec,
    .load_val(LAT_LOAD),
    .zero(cnt_zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= ST_IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    ld = 1'b0;
    dec = 1'b0;
    case (st)
      ST_IDLE: if (req_valid) begin
        ld = 1'b1;
        nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (cnt_zero) nxt = ST_RESP; else dec = 1'b1;
      ST_RESP: if (resp_ready) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end
  assign req_ready = st == ST_IDLE;
  assign resp_valid = st == ST_RESP;
  assign enter_resp = nxt == ST_RESP && st != ST_RESP;
  // bypass the request latches so a single-cycle build can commit in its accept cycle
  assign wr_c = ld ? req_write : wr_q;
  assign idx_c = ld ? req_addr[OFS+IDX_W-1:OFS] : idx_q;
  assign wdata_c = ld ? req_wdata : wdata_q;
  always_ff @(posedge clk) begin
    if (ld) begin
      wr_q <= req_write;
      idx_q <= req_addr[OFS+IDX_W-1:OFS];
      wdata_q <= req_wdata;
    end
    if (enter_resp && wr_c) mem[idx_c] <= wdata_c;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      resp_write <= 1'b0;
      resp_rdata <= '0;
    end else if (enter_resp) begin
      resp_write <= wr_c;
      resp_rdata <= wr_c ? '0 : mem[idx_c];
    end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: scoreboard bench for the main-memory responder (LATENCY 4 and 1 builds)
module tb_main_mem_responder;
  localparam int LW = 128;
  localparam int LAT = 4;
  typedef struct {bit wr; int idx; logic [LW-1:0] d; bit known; int t;} txn_t;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_write = 0, resp_ready = 0;
  logic [31:0] req_addr = '0;
  logic [LW-1:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_write;
  logic [LW-1:0] resp_rdata;
  logic v1 = 0, w1 = 0;
  logic [31:0] a1 = '0;
  logic [LW-1:0] d1 = '0;
  logic rdy1, rv1, rw1;
  logic [LW-1:0] rd1;
  int cyc = 0, total = 0, bad = 0;
  txn_t q[$];
  txn_t mon_e;
  logic [LW-1:0] model [256];
  bit known [256];
  bit prev_v = 0;
  main_mem_responder u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata)
  );
  main_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
    .req_write(w1), .req_addr(a1), .req_wdata(d1),
    .resp_valid(rv1), .resp_ready(1'b1), .resp_write(rw1), .resp_rdata(rd1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) & 32'hff);
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_v = 0;
    end else begin
      if (resp_valid && !prev_v) begin
        if (q.size() == 0) chk("spurious_resp", 1, 0);
        else chk("latency", LW'(cyc - q[0].t), LW'(LAT));
      end
      if (resp_valid && resp_ready && q.size() > 0) begin
        mon_e = q.pop_front();
        chk("resp_write", LW'(resp_write), LW'(mon_e.wr));
        if (mon_e.wr) begin
          chk("wack_rdata", resp_rdata, '0);
          model[mon_e.idx] = mon_e.d;
          known[mon_e.idx] = 1;
        end else if (mon_e.known) chk("rdata", resp_rdata, mon_e.d);
      end
      if (req_valid && req_ready)
        q.push_back('{req_write, line_of(req_addr),
                      req_write ? req_wdata : model[line_of(req_addr)],
                      req_write ? 1'b1 : known[line_of(req_addr)], cyc});
      prev_v = resp_valid;
    end
  end
  task automatic send(input bit wr, input logic [31:0] a, input logic [LW-1:0] d);
    int n = 0;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid = 0; req_write = 'x; req_addr = 'x; req_wdata = 'x;
  endtask
  task automatic wait_done(input bit rnd);
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 200) begin
      if (rnd) resp_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("resp_timeout", 1, 0);
    resp_ready = 1;
  endtask
  initial begin
    logic [LW-1:0] pd, rd;
    logic [31:0] ra;
    bit rw;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", LW'(req_ready), 1);
    chk("rst_resp_valid", LW'(resp_valid), 0);
    chk("rst_resp_write", LW'(resp_write), 0);
    chk("rst_resp_rdata", resp_rdata, '0);
    reset = 0;
    @(posedge clk); #1;
    resp_ready = 1;
    send(1, 32'h40, 128'h11112222_33334444_55556666_DEADBEEF); wait_done(0);
    send(0, 32'h40, '0); wait_done(0);
    resp_ready = 0;
    send(0, 32'h40, '0);
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall_first_rdata", resp_rdata, 128'h11112222_33334444_55556666_DEADBEEF);
    req_valid = 1; req_write = 1; req_addr = 32'h40; req_wdata = '1;
    repeat (6) begin
      @(negedge clk);
      chk("stall_valid", LW'(resp_valid), 1);
      chk("stall_rdata", resp_rdata, 128'h11112222_33334444_55556666_DEADBEEF);
      chk("stall_req_ready", LW'(req_ready), 0);
    end
    @(posedge clk); #1;
    req_valid = 0; resp_ready = 1;
    @(negedge clk);
    chk("hs_req_ready", LW'(req_ready), 0);
    @(negedge clk);
    chk("idle_req_ready", LW'(req_ready), 1);
    chk("idle_resp_valid", LW'(resp_valid), 0);
    @(posedge clk); #1;
    send(0, 32'h40, '0); wait_done(0);
    send(1, 32'h1000, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0); wait_done(0);
    send(0, 32'h0000, '0); wait_done(0);
    chk("alias_model", model[0], 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);
    send(1, 32'h80, 128'hC0FFEE); wait_done(0);
    send(1, 32'h80, 128'hBAD0BAD);
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("midwait_req_ready", LW'(req_ready), 1);
    chk("midwait_resp_valid", LW'(resp_valid), 0);
    chk("midwait_resp_write", LW'(resp_write), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    send(0, 32'h80, '0); wait_done(0);
    chk("abandon_model", model[8], 128'hC0FFEE);
    resp_ready = 0;
    send(0, 32'h80, '0);
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("resp_before_rst", LW'(resp_valid), 1);
    #2 reset = 1;
    #1 chk("resp_drop_on_rst", LW'(resp_valid), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    resp_ready = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rw = (i % 2) == 0;
      if (rw) pd = {$urandom, $urandom, $urandom, $urandom};
      v1 = 1; w1 = rw; a1 = 32'(i / 2) << 4; d1 = pd;
      @(negedge clk);
      chk("l1_ready", LW'(rdy1), 1);
      chk("l1_idle_valid", LW'(rv1), 0);
      @(negedge clk);
      chk("l1_valid", LW'(rv1), 1);
      chk("l1_busy", LW'(rdy1), 0);
      chk("l1_write", LW'(rw1), LW'(rw));
      chk("l1_rdata", rd1, rw ? '0 : pd);
    end
    v1 = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      rw = $urandom_range(0, 1) == 1;
      ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 4) | 32'($urandom_range(0, 15));
      rd = {$urandom, $urandom, $urandom, $urandom};
      send(rw, ra, rd);
      wait_done(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
